// File: rtl/if_fetch_buf.sv
// Instruction fetch stage: split-transaction instruction port, one outstanding request, small FIFO to decode.
// Optional build macro IF_ADEF_EN: misaligned PCs push an address-error entry instead of fetching.
module if_fetch_buf #(
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter logic [31:0] EX_ENTRY   = 32'hbfc00380,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  input  logic        ws_ex,
  input  logic [32:0] ex_return,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(IBUF_DEPTH);

  logic        br_taken, eret_flush, flush;
  logic [31:0] br_target, epc;
  assign {br_taken, br_target} = br_bus;
  assign {eret_flush, epc}     = ex_return;

  logic [64:0]   mem_q [IBUF_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d, ipc_q, ipc_d, tgt_q, tgt_d;
  logic          out_q, out_d, disc_q, disc_d, keep_q, keep_d;
  logic          can_issue, accept, resp, pop, push, adef_push;
  logic [64:0]   push_data;

  assign flush     = ws_ex | eret_flush | br_taken;
  // Issue only with a free FIFO slot, so every accepted fetch has room to land.
  assign can_issue = resetn && !out_q && (cnt_q != FULL_CNT) && !flush;

`ifdef IF_ADEF_EN
  logic stall_q, stall_d, pc_bad;
  assign pc_bad         = |pc_q[1:0];
  assign inst_sram_req  = can_issue && !pc_bad;
  assign adef_push      = can_issue && pc_bad && !stall_q;
  assign inst_sram_addr = pc_q;
`else
  assign inst_sram_req  = can_issue;
  assign adef_push      = 1'b0;
  assign inst_sram_addr = {pc_q[31:2], 2'b00};
`endif

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;

  assign accept         = inst_sram_req && inst_sram_addr_ok;
  assign resp           = inst_sram_data_ok && out_q;
  assign fs_to_ds_valid = (cnt_q != '0);
  assign fs_to_ds_bus   = mem_q[rd_ptr_q];
  assign pop            = fs_to_ds_valid && ds_allowin;
  assign push_data      = adef_push ? {1'b1, 32'h0, pc_q} : {1'b0, inst_sram_rdata, ipc_q};

  always_comb begin
    pc_d     = pc_q;
    ipc_d    = ipc_q;
    tgt_d    = tgt_q;
    out_d    = out_q;
    disc_d   = disc_q;
    keep_d   = keep_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    push     = (resp && !disc_q) || adef_push;
`ifdef IF_ADEF_EN
    stall_d  = stall_q || adef_push;
`endif
    if (accept) begin
      out_d = 1'b1;
      ipc_d = pc_q;
      if (keep_q) begin
        pc_d   = tgt_q;
        keep_d = 1'b0;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
    if (resp) begin
      out_d  = 1'b0;
      disc_d = 1'b0;
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (ws_ex || eret_flush) begin
      push     = 1'b0;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = rd_ptr_q;
      cnt_d    = '0;
      disc_d   = out_d;
      pc_d     = ws_ex ? EX_ENTRY : epc;
      keep_d   = 1'b0;
`ifdef IF_ADEF_EN
      stall_d  = 1'b0;
`endif
    end else if (br_taken) begin
      if (cnt_q != '0) begin
        // Head is the delay slot; everything younger, queued or in flight, is dropped.
        push     = 1'b0;
        disc_d   = out_d;
        wr_ptr_d = rd_ptr_q + PW'(1);
        cnt_d    = pop ? CW'(0) : CW'(1);
        pc_d     = br_target;
`ifdef IF_ADEF_EN
        stall_d  = 1'b0;
`endif
      end else if (out_q) begin
        pc_d = br_target;
`ifdef IF_ADEF_EN
        stall_d = 1'b0;
`endif
      end else begin
        keep_d = 1'b1;
        tgt_d  = br_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q     <= RESET_PC;
      ipc_q    <= RESET_PC;
      tgt_q    <= RESET_PC;
      out_q    <= 1'b0;
      disc_q   <= 1'b0;
      keep_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      ipc_q    <= ipc_d;
      tgt_q    <= tgt_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      keep_q   <= keep_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef IF_ADEF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stall_q <= 1'b0;
    else         stall_q <= stall_d;
  end
`endif

endmodule

// File: doc/if_fetch_buf.md
# if_fetch_buf

Instruction-fetch stage for the pipelined CPU, driving a split-transaction SRAM-like instruction port (req/addr_ok/data_ok) in place of a fixed one-cycle SRAM. It generates the fetch PC, keeps at most one request outstanding and holds returned instructions in a parametrised FIFO ahead of decode. It handles branch redirection with a one-instruction delay slot, exception entry and eret return, and discards stale in-flight responses. It sits between the instruction bus bridge and id_stage.

## Interface
- RESET_PC, 32'hbfc00000: first fetch address after reset
- EX_ENTRY, 32'hbfc00380: fetch address on ws_ex
- IBUF_DEPTH, 2: instruction FIFO entries; power of 2, ≥2
---
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ds_allowin  in  1  decode accepts an instruction this cycle
- br_bus  in  33  {br_taken, br_target}; br_taken is a one-cycle pulse
- ws_ex  in  1  exception committed in WB (one-cycle pulse)
- ex_return  in  33  {eret_flush, epc}; eret_flush is a one-cycle pulse
- fs_to_ds_valid  out  1  FIFO head valid
- fs_to_ds_bus  out  65  {adef, inst[31:0], pc[31:0]} of the FIFO head
- inst_sram_req  out  1  request valid
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'd2
- inst_sram_wstrb  out  4  constant 0
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr  out  32  fetch address
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  response valid
- inst_sram_rdata  in  32  response data

## Operation
- State: pc register, FIFO (count 0..IBUF_DEPTH), outstanding flag, discard flag, ds_keep counter (0/1).
- Issue: req=1 when no outstanding request, count+outstanding < IBUF_DEPTH, and not in a flush cycle. While req=1 and addr_ok=0, req and addr are held stable. A request counts as outstanding from the addr_ok edge until the data_ok edge.
- Accept (req && addr_ok): pc ← pc+4 (32-bit wrap), outstanding ← 1.
- Response (data_ok && outstanding):
  - discard=1: drop the data and clear discard.
  - Otherwise: push {0, rdata, issued pc}.
  - If data_ok arrives with no outstanding request, ignore it.
- Pop: fs_to_ds_valid && ds_allowin. Push and pop may occur in the same cycle; count is unchanged in that case.
- Redirect priority: ws_ex > eret_flush > br_taken.
- ws_ex / eret_flush:
  - Clear the FIFO.
  - discard ← outstanding, or ← 1 if accepted this cycle.
  - pc ← EX_ENTRY or epc.
  - Cancel any held, unaccepted req; it is reissued at the new pc next cycle.
- br_taken keeps exactly one instruction after the branch (the delay slot):
  - FIFO non-empty: retain the head only; discard any in-flight response; pc ← br_target.
  - FIFO empty and a request is outstanding: keep that response; pc ← br_target.
  - FIFO empty and nothing outstanding: ds_keep ← 1. The next sequential fetch completes normally, then pc ← br_target when it is accepted.

## Timing
- Reset values: fs_to_ds_valid=0, inst_sram_req=0, FIFO empty, outstanding=0, discard=0, pc=RESET_PC.
- The first req is asserted in the first cycle after resetn deasserts, with addr=RESET_PC.
- Latency: data_ok at edge N gives fs_to_ds_valid=1 after edge N (registered FIFO output).
- A new request may issue in the cycle after data_ok (one outstanding maximum).
- FIFO full: req stays low, and data is never lost because issue reserves a slot.
- Redirect mid-handshake: an address accepted in the same cycle as the redirect is marked for discard.
- Reset asserted mid-transaction: all state clears immediately. A data_ok that arrives later is ignored because outstanding=0.

## Configuration
- IF_ADEF_EN defined:
  - A pc with pc[1:0]≠0 issues no bus request.
  - Instead, push {1, 32'h0, pc} once (subject to FIFO space), then stall issue until a redirect arrives.
- IF_ADEF_EN undefined:
  - inst_sram_addr = {pc[31:2], 2'b00}.
  - adef is tied 0.

## Test plan
- Reset release, addr_ok=1, data_ok one cycle later, rdata=32'h24010001: addr 32'hbfc00000, then bus {0,32'h24010001,32'hbfc00000}. Sequential addrs follow +4.
- ds_allowin=0 with IBUF_DEPTH=2: exactly 2 responses buffered, req stays 0, no lost instructions. Releasing ds_allowin pops in order.
- br_taken (target 32'hbfc00100) with 2 entries queued: only the head is delivered, then pc 32'hbfc00100. The next fetch after that is 32'hbfc00104.
- ws_ex while a request is outstanding: the stale data_ok is dropped, and the next req addr is 32'hbfc00380.
- eret_flush with epc=32'hbfc00040 in the same cycle as ws_ex: ws_ex wins (EX_ENTRY). eret_flush alone: next addr is 32'hbfc00040.
- IF_ADEF_EN with eret to 32'hbfc00042: no req, bus {1,0,32'hbfc00042}.
